// File: rtl/ls_order_queue.sv
// ls_order_queue -- in-order load/store issue queue with result-bus snooping.
//
// Dispatched memory ops enter a circular FIFO. Each entry keeps two source
// operands (base and store data). A source whose tag is non-zero still waits
// for a producer. Every cycle, each waiting source watches CDB_N broadcast
// channels and captures its value when the producer's tag appears. Only the
// head entry may issue, so memory ops leave in program order. The head moves
// into a one-entry output register once both of its operands are ready.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   cdb_en/cdb_tag/cdb_data  broadcast channels; channel c at [c*W +: W]
//   in_valid/in_ready        dispatch handshake; in_ready = !full
//   in_opnd_o/in_opnd_t      base operand / store-data operand
//   in_imm                   address offset
//   in_tag_o/in_tag_t        source tags (0 = operand already present)
//   in_tag_w/in_name_w       destination tag / register (name 0 = no writeback)
//   in_op                    opcode
//   out_valid/out_ready      issue handshake to the LS unit
//   out_*                    issued entry fields
//   flush                    synchronous squash of queue and output register
//   count/full/empty         queue occupancy (output register not counted)
module ls_order_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CDB_N-1:0]        cdb_en,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_opnd_o,
    input  logic [DATA_W-1:0]       in_opnd_t,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [TAG_W-1:0]        in_tag_o,
    input  logic [TAG_W-1:0]        in_tag_t,
    input  logic [TAG_W-1:0]        in_tag_w,
    input  logic [NAME_W-1:0]       in_name_w,
    input  logic [OP_W-1:0]         in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_opnd_o,
    output logic [DATA_W-1:0]       out_opnd_t,
    output logic [DATA_W-1:0]       out_imm,
    output logic [TAG_W-1:0]        out_tag_w,
    output logic [NAME_W-1:0]       out_name_w,
    output logic [OP_W-1:0]         out_op,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    // Returns {hit, data}. Channels are scanned from the highest index down,
    // so when several channels match, the lowest index is written last and wins.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_N-1:0]        en,
        input logic [CDB_N*TAG_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        if (tag != '0) begin
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (en[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                    r = {1'b1, data[c*DATA_W +: DATA_W]};
                end
            end
        end
        return r;
    endfunction

    logic [DATA_W-1:0] opnd_o_mem [DEPTH];
    logic [DATA_W-1:0] opnd_t_mem [DEPTH];
    logic [DATA_W-1:0] imm_mem    [DEPTH];
    logic [TAG_W-1:0]  tag_o_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_t_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_w_mem  [DEPTH];
    logic [NAME_W-1:0] name_w_mem [DEPTH];
    logic [OP_W-1:0]   op_mem     [DEPTH];

    logic [AW:0]       head_ptr;
    logic [AW:0]       tail_ptr;
    logic [AW-1:0]     head_idx;
    logic [AW-1:0]     tail_idx;
    logic              enq;
    logic              head_ready;
    logic              pop;
    logic [DATA_W:0]   enq_snoop_o;
    logic [DATA_W:0]   enq_snoop_t;
    logic [DATA_W:0]   snoop_o [DEPTH];
    logic [DATA_W:0]   snoop_t [DEPTH];

    assign head_idx = head_ptr[AW-1:0];
    assign tail_idx = tail_ptr[AW-1:0];
    assign empty    = (head_ptr == tail_ptr);
    assign full     = (head_ptr[AW] != tail_ptr[AW]) && (head_idx == tail_idx);
    assign count    = tail_ptr - head_ptr;
    assign in_ready = !full;
    assign enq      = in_valid && in_ready;

    // Readiness uses the registered tags, so a head operand captured from the
    // bus this edge only allows issue on the following edge.
    assign head_ready = !empty && (tag_o_mem[head_idx] == '0) && (tag_t_mem[head_idx] == '0);
    assign pop        = head_ready && (!out_valid || out_ready);

    assign enq_snoop_o = cdb_match(in_tag_o, cdb_en, cdb_tag, cdb_data);
    assign enq_snoop_t = cdb_match(in_tag_t, cdb_en, cdb_tag, cdb_data);

    // All slots are snooped. Matches in free slots have no effect, because a
    // slot is fully rewritten when it is enqueued.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop_o[i] = cdb_match(tag_o_mem[i], cdb_en, cdb_tag, cdb_data);
            snoop_t[i] = cdb_match(tag_t_mem[i], cdb_en, cdb_tag, cdb_data);
        end
    end

    // Entry storage. Validity comes from the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (tail_idx == AW'(i))) begin
                opnd_o_mem[i] <= enq_snoop_o[DATA_W] ? enq_snoop_o[DATA_W-1:0] : in_opnd_o;
                tag_o_mem[i]  <= enq_snoop_o[DATA_W] ? '0 : in_tag_o;
                opnd_t_mem[i] <= enq_snoop_t[DATA_W] ? enq_snoop_t[DATA_W-1:0] : in_opnd_t;
                tag_t_mem[i]  <= enq_snoop_t[DATA_W] ? '0 : in_tag_t;
                imm_mem[i]    <= in_imm;
                tag_w_mem[i]  <= in_tag_w;
                name_w_mem[i] <= in_name_w;
                op_mem[i]     <= in_op;
            end else begin
                if (snoop_o[i][DATA_W]) begin
                    opnd_o_mem[i] <= snoop_o[i][DATA_W-1:0];
                    tag_o_mem[i]  <= '0;
                end
                if (snoop_t[i][DATA_W]) begin
                    opnd_t_mem[i] <= snoop_t[i][DATA_W-1:0];
                    tag_t_mem[i]  <= '0;
                end
            end
        end
    end

    // Pointers and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            out_valid  <= 1'b0;
            out_opnd_o <= '0;
            out_opnd_t <= '0;
            out_imm    <= '0;
            out_tag_w  <= '0;
            out_name_w <= '0;
            out_op     <= '0;
        end else if (flush) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (enq) begin
                tail_ptr <= tail_ptr + (AW+1)'(1);
            end
            if (pop) begin
                head_ptr   <= head_ptr + (AW+1)'(1);
                out_valid  <= 1'b1;
                out_opnd_o <= opnd_o_mem[head_idx];
                out_opnd_t <= opnd_t_mem[head_idx];
                out_imm    <= imm_mem[head_idx];
                out_name_w <= name_w_mem[head_idx];
                out_op     <= op_mem[head_idx];
                // A destination tag without a writeback register is meaningless.
                out_tag_w  <= (name_w_mem[head_idx] == '0) ? '0 : tag_w_mem[head_idx];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ls_order_queue.sv
// Testbench for ls_order_queue. Stimulus pushes expected issue records into a
// scoreboard queue. A monitor on the falling edge pops one record for each
// accepted output transfer and compares it. Directed checks cover status and
// timing.
module tb_ls_order_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int NAME_W = 5;
    localparam int OP_W   = 6;
    localparam int CDB_N  = 2;

    logic                    clk;
    logic                    rst;
    logic [CDB_N-1:0]        cdb_en;
    logic [CDB_N*TAG_W-1:0]  cdb_tag;
    logic [CDB_N*DATA_W-1:0] cdb_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_opnd_o;
    logic [DATA_W-1:0]       in_opnd_t;
    logic [DATA_W-1:0]       in_imm;
    logic [TAG_W-1:0]        in_tag_o;
    logic [TAG_W-1:0]        in_tag_t;
    logic [TAG_W-1:0]        in_tag_w;
    logic [NAME_W-1:0]       in_name_w;
    logic [OP_W-1:0]         in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_opnd_o;
    logic [DATA_W-1:0]       out_opnd_t;
    logic [DATA_W-1:0]       out_imm;
    logic [TAG_W-1:0]        out_tag_w;
    logic [NAME_W-1:0]       out_name_w;
    logic [OP_W-1:0]         out_op;
    logic                    flush;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;

    typedef struct {
        logic [31:0] op;
        logic [31:0] imm;
        logic [31:0] opnd_o;
        logic [31:0] opnd_t;
        logic [31:0] tag_w;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails  = 0;

    ls_order_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .NAME_W(NAME_W), .OP_W(OP_W), .CDB_N(CDB_N)
    ) dut (
        .clk(clk), .rst(rst),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opnd_o(in_opnd_o), .in_opnd_t(in_opnd_t), .in_imm(in_imm),
        .in_tag_o(in_tag_o), .in_tag_t(in_tag_t), .in_tag_w(in_tag_w),
        .in_name_w(in_name_w), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opnd_o(out_opnd_o), .out_opnd_t(out_opnd_t), .out_imm(out_imm),
        .out_tag_w(out_tag_w), .out_name_w(out_name_w), .out_op(out_op),
        .flush(flush), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && ready
    // is seen here. Inputs change only just after rising edges.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: got imm=%0h expected no issue", out_imm);
            end else begin
                mon_e = sb.pop_front();
                if (32'(out_op) !== mon_e.op || out_imm !== mon_e.imm ||
                    out_opnd_o !== mon_e.opnd_o || out_opnd_t !== mon_e.opnd_t ||
                    32'(out_tag_w) !== mon_e.tag_w) begin
                    fails++;
                    $display("FAIL issue: got op=%0h imm=%0h o=%0h t=%0h tw=%0h expected op=%0h imm=%0h o=%0h t=%0h tw=%0h",
                             out_op, out_imm, out_opnd_o, out_opnd_t, out_tag_w,
                             mon_e.op, mon_e.imm, mon_e.opnd_o, mon_e.opnd_t, mon_e.tag_w);
                end else begin
                    $display("issue op=%0h imm=%0h o=%0h t=%0h tw=%0h ok",
                             out_op, out_imm, out_opnd_o, out_opnd_t, out_tag_w);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for in_ready, then presents one entry for one edge.
    task automatic enq(input logic [31:0] op, input logic [31:0] imm,
                       input logic [31:0] oo, input logic [31:0] ot,
                       input logic [31:0] to, input logic [31:0] tt,
                       input logic [31:0] tw, input logic [31:0] nw,
                       input logic [31:0] exp_o, input logic [31:0] exp_t_v);
        exp_t e;
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL enq_timeout: got in_ready=0 expected 1 (imm=%0h)", imm);
        end else begin
            in_op     = op[OP_W-1:0];
            in_imm    = imm;
            in_opnd_o = oo;
            in_opnd_t = ot;
            in_tag_o  = to[TAG_W-1:0];
            in_tag_t  = tt[TAG_W-1:0];
            in_tag_w  = tw[TAG_W-1:0];
            in_name_w = nw[NAME_W-1:0];
            in_valid  = 1'b1;
            e.op      = op;
            e.imm     = imm;
            e.opnd_o  = exp_o;
            e.opnd_t  = exp_t_v;
            e.tag_w   = (nw == 0) ? 32'h0 : tw;
            sb.push_back(e);
            $display("enqueue op=%0h imm=%0h tag_o=%0h tag_t=%0h", op, imm, to, tt);
            tick(1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick(1);
            n++;
        end
        chk(name, 32'(sb.size()) | 32'(out_valid), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        cdb_en = '0; cdb_tag = '0; cdb_data = '0;
        in_valid = 1'b0; in_opnd_o = '0; in_opnd_t = '0; in_imm = '0;
        in_tag_o = '0; in_tag_t = '0; in_tag_w = '0; in_name_w = '0; in_op = '0;
        out_ready = 1'b0; flush = 1'b0;

        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_imm", out_imm, 32'h0);
        #10 rst = 1'b1;
        tick(1);

        // Minimum latency: out_valid after the second edge.
        out_ready = 1'b1;
        enq(3, 32'h10, 0, 0, 0, 0, 9, 2, 0, 0);
        chk("lat_valid_edge1", 32'(out_valid), 32'h0);
        chk("lat_count_edge1", 32'(count), 32'h1);
        tick(1);
        chk("lat_valid_edge2", 32'(out_valid), 32'h1);
        chk("lat_imm", out_imm, 32'h10);
        chk("lat_count_edge2", 32'(count), 32'h0);
        tick(2);

        // In-order issue: pending A blocks ready B until the broadcast arrives.
        enq(1, 32'h20, 0, 32'h55, 5, 0, 6, 0, 32'hDEAD, 32'h55);
        enq(2, 32'h24, 32'h1234, 32'h99, 0, 0, 7, 3, 32'h1234, 32'h99);
        tick(3);
        chk("order_blocked_valid", 32'(out_valid), 32'h0);
        chk("order_blocked_count", 32'(count), 32'h2);
        cdb_en = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_data = {32'h0, 32'hDEAD};
        tick(1);
        cdb_en = '0;
        chk("snoop_pop_waits", 32'(out_valid), 32'h0);
        tick(1);
        chk("a_issued_valid", 32'(out_valid), 32'h1);
        chk("a_issued_opnd_o", out_opnd_o, 32'hDEAD);
        tick(1);
        chk("b_next_edge_imm", out_imm, 32'h24);
        wait_drain("drain_order");

        // Two channels match the same tag: channel 0 wins.
        enq(4, 32'h30, 0, 0, 7, 7, 2, 1, 32'h11, 32'h11);
        tick(1);
        chk("prio_waiting", 32'(out_valid), 32'h0);
        cdb_en = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_data = {32'h22, 32'h11};
        tick(1);
        cdb_en = '0;
        wait_drain("drain_prio");

        // Broadcast on the enqueue edge is captured by the incoming entry.
        cdb_en = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_data = {32'h0, 32'hBEEF};
        enq(5, 32'h40, 0, 32'h77, 3, 0, 1, 4, 32'hBEEF, 32'h77);
        cdb_en = '0;
        wait_drain("drain_bypass");

        // Fill: one in the output register and eight in the queue.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) enq(6, i, i, 0, 0, 0, 0, 0, i, 0);
        chk("fill_count", 32'(count), 32'h8);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_in_ready", 32'(in_ready), 32'h0);
        chk("fill_out_valid", 32'(out_valid), 32'h1);
        in_imm = 32'hFFFF; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("full_ignored_count", 32'(count), 32'h8);
        chk("stall_hold_imm", out_imm, 32'h0);
        out_ready = 1'b1;
        for (int i = 9; i < 20; i++) enq(6, i, i, 0, 0, 0, 0, 0, i, 0);
        wait_drain("drain_wrap");

        // Flush overrides a same-edge enqueue and clears the output register.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) enq(7, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_flush_count", 32'(count), 32'h5);
        chk("pre_flush_valid", 32'(out_valid), 32'h1);
        in_imm = 32'hBAD; in_valid = 1'b1; flush = 1'b1;
        tick(1);
        in_valid = 1'b0; flush = 1'b0;
        sb.delete();
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_empty", 32'(empty), 32'h1);
        out_ready = 1'b1;
        tick(3);
        chk("flush_dropped_valid", 32'(out_valid), 32'h0);
        chk("flush_dropped_count", 32'(count), 32'h0);
        enq(8, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain("drain_after_flush");

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        enq(9, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        enq(9, 32'h301, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_out_imm", out_imm, 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(1);
        enq(10, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain("drain_after_reset");

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ls_order_queue.md
LS_ORDER_QUEUE -- requirements
Module: ls_order_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, minimum 2.
REQ-002 Parameter DATA_W, default 32, operand/imm/CDB data width.
REQ-003 Parameter TAG_W, default 4, rename-tag width; tag value 0 = no dependency.
REQ-004 Parameter NAME_W, default 5, destination register name width; value 0 = no writeback.
REQ-005 Parameter OP_W, default 6, opcode width.
REQ-006 Parameter CDB_N, default 2, number of snooped broadcast channels.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  clock, all state on rising edge.
REQ-009 rst  input  1  asynchronous active-low reset.
REQ-010 cdb_en  input  CDB_N  per-channel broadcast valid.
REQ-011 cdb_tag  input  CDB_N*TAG_W  per-channel tag, channel c at bits [c*TAG_W +: TAG_W].
REQ-012 cdb_data  input  CDB_N*DATA_W  per-channel result data.
REQ-013 in_valid / in_ready  input / output  1 / 1  dispatch handshake.
REQ-014 in_opnd_o, in_opnd_t, in_imm  input  DATA_W each  base, store-data, offset.
REQ-015 in_tag_o, in_tag_t, in_tag_w  input  TAG_W each  source tags, destination tag.
REQ-016 in_name_w  input  NAME_W;  in_op  input  OP_W.
REQ-017 out_valid / out_ready  output / input  1 / 1  issue handshake to LS unit.
REQ-018 out_opnd_o, out_opnd_t, out_imm  output  DATA_W each;  out_tag_w  output  TAG_W;  out_name_w  output  NAME_W;  out_op  output  OP_W.
REQ-019 flush  input  1  synchronous squash of all contents.
REQ-020 count  output  clog2(DEPTH)+1  occupied entries (queue only, excluding output register).
REQ-021 full / empty  output  1 / 1  queue status.

Function
REQ-022 Entries held as circular FIFO, head/tail pointers with extra wrap bit; full when pointers equal except wrap bit, empty when fully equal.
REQ-023 in_ready = !full (combinational); enqueue occurs on edge where in_valid && in_ready; no enqueue when full even if head pops same edge.
REQ-024 Enqueued entry stores all in_* fields; source tag 0 means operand already valid.
REQ-025 Snoop: every edge, for each occupied entry and each pending source (tag != 0), if any enabled channel matches the tag, capture that channel's data and clear the tag to 0.
REQ-026 Multiple matching channels same cycle: lowest channel index wins.
REQ-027 Enqueue bypass: an incoming source tag matching an enabled channel on the enqueue edge is stored as ready with that channel's data.
REQ-028 Issue strictly in program order: only head entry may leave; younger ready entries wait.
REQ-029 Head pops into output register on edge where head occupied, both head tags 0, and (out_valid == 0 or out_ready == 1).
REQ-030 Output register holds value stable while out_valid && !out_ready; out_valid deasserts after drain edge with no pop.
REQ-031 out_tag_w = 0 when out_name_w = 0, else stored in_tag_w.
REQ-032 Minimum latency: entry enqueued ready at edge k presents out_valid after edge k+1.
REQ-033 Simultaneous enqueue and pop: count unchanged; both pointers advance.
REQ-034 Snoop for head operand and pop on same edge: pop waits; head issues next edge.
REQ-035 flush: next edge empties queue and output register (out_valid=0, count=0), overriding enqueue, pop and snoop that edge.
REQ-036 Pointer wrap from DEPTH-1 to 0 toggles wrap bit; no data loss across wrap.

Reset
REQ-037 rst low asynchronously clears pointers, count=0, empty=1, full=0, in_ready=1, out_valid=0, all out_* data fields 0.
REQ-038 rst asserted mid-operation discards all entries and output register contents immediately; first enqueue accepted on first rising edge after rst high.

Verification
REQ-039 Reset then enqueue op=3, tag_o=0, tag_t=0, imm=0x10, out_ready=1 -> out_valid after second edge, out_imm=0x10, count back to 0.
REQ-040 Enqueue A with tag_o=5, then B ready -> neither issues; cdb_en=01, cdb_tag=5, data=0xDEAD -> A issues with out_opnd_o=0xDEAD, B next edge.
REQ-041 Both channels broadcast tag 7 with 0x11 (ch0) and 0x22 (ch1) to pending entry -> captured 0x11.
REQ-042 Fill 8 entries with out_ready=0 -> full=1, in_ready=0, count=8; further in_valid ignored; release out_ready -> order preserved across wrap for 20 total entries.
REQ-043 Enqueue with in_tag_o=3 while cdb broadcasts tag 3, 0xBEEF -> entry stored ready, issues without further broadcast.
REQ-044 Flush with 5 entries and out_valid=1, in_valid=1 same edge -> count=0, out_valid=0, empty=1, incoming entry dropped.
